// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset controller:
// state encodings, opcodes, ALU operation classes and datapath select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational decode of controller state and opcode into datapath controls.
// Everything is forced low while reset is held so no strobe escapes an abort.
module multicycle_ctrl_outdec
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] op,
  input  logic       rst,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  always_comb begin
    pc_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_B;
    alu_op_o     = ALU_ADD;
    pc_source_o  = PCSRC_ALU;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          mem_read_o  = 1'b1;
          ir_write_o  = mem_ready;
          pc_write_o  = mem_ready;
          alu_src_b_o = SRCB_FOUR;
        end
        // ALUOut captures PC+4 + (imm << 2) as the branch target
        ST_DECODE: begin
          alu_src_b_o = SRCB_IMM_SH2;
          illegal_o   = !op_supported(op);
        end
        ST_EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_FUNCT;
        end
        ST_WB_R: begin
          reg_dst_o    = 1'b1;
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        ST_EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
          alu_op_o    = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        ST_WB_I: begin
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        ST_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
        end
        ST_MEM_RD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        ST_WB_MEM: begin
          mem_to_reg_o = 1'b1;
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        ST_MEM_WR: begin
          mem_write_o  = 1'b1;
          iord_o       = 1'b1;
          instr_done_o = mem_ready;
        end
        ST_BRANCH: begin
          alu_src_a_o  = 1'b1;
          alu_op_o     = ALU_SUB;
          pc_source_o  = PCSRC_ALUOUT;
          pc_write_o   = (op == OP_BNE) ? !zero : zero;
          instr_done_o = 1'b1;
        end
        ST_JUMP: begin
          pc_source_o  = PCSRC_JUMP;
          pc_write_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset sequencer: state register, held opcode and next-state logic.
//   state     | meaning
//   FETCH     | read instruction at PC, PC += 4 on mem ready
//   DECODE    | branch target into ALUOut, dispatch on opcode
//   EXEC_R    | ALU A op B (funct)
//   WB_R      | write ALUOut to rd
//   EXEC_I    | ALU A op imm (addi/slti)
//   WB_I      | write ALUOut to rt
//   MEM_ADDR  | ALU A + imm for lw/sw
//   MEM_RD    | data read at ALUOut until ready
//   WB_MEM    | write MDR to rt
//   MEM_WR    | data write at ALUOut until ready
//   BRANCH    | compare A-B, take ALUOut on beq/bne condition
//   JUMP      | load jump target
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic [5:0] op_eff;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FETCH;
      op_q    <= OP_RTYPE;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= instr_op_i;
    end
  end

  // The IR may be reloaded later, so only DECODE trusts instr_op_i directly
  assign op_eff = (state_q == ST_DECODE) ? instr_op_i : op_q;

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:    state_d = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:         state_d = ST_EXEC_R;
          OP_ADDI, OP_SLTI: state_d = ST_EXEC_I;
          OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = ST_BRANCH;
          OP_J:             state_d = ST_JUMP;
          default:          state_d = ST_FETCH;
        endcase
      end
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_EXEC_I:   state_d = ST_WB_I;
      ST_MEM_ADDR: state_d = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   state_d = mem_ready_i ? ST_WB_MEM : ST_MEM_RD;
      ST_MEM_WR:   state_d = mem_ready_i ? ST_FETCH : ST_MEM_WR;
      default:     state_d = ST_FETCH;
    endcase
  end

  assign state_o = rst_i ? 4'd0 : state_q;

  multicycle_ctrl_outdec u_outdec (
    .state        (state_q),
    .op           (op_eff),
    .rst          (rst_i),
    .zero         (zero_i),
    .mem_ready    (mem_ready_i),
    .pc_write_o   (pc_write_o),
    .iord_o       (iord_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .ir_write_o   (ir_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .pc_source_o  (pc_source_o),
    .instr_done_o (instr_done_o),
    .illegal_o    (illegal_o)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: fixed state-trace vectors, hand-written corner
// sequences, and random instructions checked against per-instruction totals.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i, zero_i, mem_ready_i;
  logic [5:0] instr_op_i;
  logic       pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic       instr_done_o, illegal_o;
  logic [3:0] state_o;
  logic [21:0] all_out;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .iord_o(iord_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .pc_source_o(pc_source_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign all_out = {pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o,
                    mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                    pc_source_o, instr_done_o, illegal_o, state_o};

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Inputs change just after the falling edge; outputs are read 2 ns later.
  task automatic cyc_step(input logic r, input logic [5:0] op, input logic z, input logic rdy);
    @(negedge clk);
    rst_i = r; instr_op_i = op; zero_i = z; mem_ready_i = rdy;
    #2;
  endtask

  typedef struct {
    logic [5:0]      op;
    logic            z;
    int              n;
    logic [4:0][3:0] st;
    logic            pcw_last;
    logic [2:0]      alu2;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] op, input logic z, input int n,
                              input logic [3:0] s0, s1, s2, s3, s4,
                              input logic pcw, input logic [2:0] alu2);
    vec_t v;
    v.op = op; v.z = z; v.n = n;
    v.st = {s4, s3, s2, s1, s0};
    v.pcw_last = pcw; v.alu2 = alu2;
    return v;
  endfunction

  typedef struct {
    int cycles, regw, memw, memr, iord, pcw, ill, done, irw, rd, mtr;
  } tot_t;

  // Reference totals for one instruction, from opcode, zero flag and memory waits.
  function automatic tot_t model(input logic [5:0] op, input logic z, input int fw, input int mw);
    tot_t e;
    logic legal, rt, imm, lw, sw, br;
    legal = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_LW) ||
            (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
    rt  = (op == OP_RTYPE);
    imm = (op == OP_ADDI) || (op == OP_SLTI);
    lw  = (op == OP_LW);
    sw  = (op == OP_SW);
    br  = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
    e.cycles = !legal ? 2 + fw : (rt || imm) ? 4 + fw : lw ? 5 + fw + mw : sw ? 4 + fw + mw : 3 + fw;
    e.regw = (rt || imm || lw) ? 1 : 0;
    e.memw = sw ? mw + 1 : 0;
    e.memr = fw + 1 + (lw ? mw + 1 : 0);
    e.iord = (lw || sw) ? mw + 1 : 0;
    e.pcw  = 1 + (((op == OP_J) || (op == OP_BEQ && z) || (op == OP_BNE && !z)) ? 1 : 0);
    e.ill  = legal ? 0 : 1;
    e.done = legal ? 1 : 0;
    e.irw  = 1;
    e.rd   = rt ? 1 : 0;
    e.mtr  = lw ? 1 : 0;
    if (!br) e.pcw = e.pcw;
    return e;
  endfunction

  // Runs one instruction from FETCH; memory waits fw cycles on the fetch and mw on the data access.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                           output tot_t a);
    int  c = 0, acc = 0, wl = fw;
    bit  ended = 0;
    a = '{default: 0};
    while (!ended && c < 40) begin
      @(negedge clk);
      rst_i = 1'b0; zero_i = z;
      instr_op_i = (c <= fw + 1) ? op : 6'($urandom_range(0, 63));
      #1;
      if (mem_read_o || mem_write_o) mem_ready_i = (wl == 0);
      else mem_ready_i = 1'($urandom_range(0, 1));
      #1;
      a.regw += reg_write_o; a.memw += mem_write_o; a.memr += mem_read_o;
      a.iord += iord_o; a.pcw += pc_write_o; a.ill += illegal_o;
      a.done += instr_done_o; a.irw += ir_write_o;
      if (reg_write_o) begin a.rd = reg_dst_o; a.mtr = mem_to_reg_o; end
      if (mem_read_o || mem_write_o) begin
        if (wl == 0) begin acc++; wl = mw; end
        else wl--;
      end
      if (instr_done_o || illegal_o) ended = 1;
      c++;
    end
    a.cycles = c;
    if (!ended) begin
      total++; bad++;
      $display("FAIL timeout: op %0h never completed within 40 cycles", op);
      cyc_step(1'b1, OP_RTYPE, 1'b0, 1'b1);
    end
  endtask

  task automatic compare(input string tag, input tot_t a, input tot_t e);
    check({tag, " cycles"}, a.cycles, e.cycles);
    check({tag, " reg_write"}, a.regw, e.regw);
    check({tag, " mem_write"}, a.memw, e.memw);
    check({tag, " mem_read"}, a.memr, e.memr);
    check({tag, " iord"}, a.iord, e.iord);
    check({tag, " pc_write"}, a.pcw, e.pcw);
    check({tag, " illegal"}, a.ill, e.ill);
    check({tag, " done"}, a.done, e.done);
    check({tag, " ir_write"}, a.irw, e.irw);
    check({tag, " reg_dst"}, a.rd, e.rd);
    check({tag, " mem_to_reg"}, a.mtr, e.mtr);
  endtask

  vec_t vecs[10];
  logic [5:0] ops[9];
  tot_t a, e;

  initial begin
    rst_i = 1'b1; instr_op_i = OP_RTYPE; zero_i = 1'b0; mem_ready_i = 1'b1;

    vecs[0] = mk(OP_RTYPE, 0, 4, 0, 1, 2, 3, 0, 0, ALU_FUNCT);
    vecs[1] = mk(OP_ADDI,  0, 4, 0, 1, 4, 5, 0, 0, ALU_ADD);
    vecs[2] = mk(OP_SLTI,  0, 4, 0, 1, 4, 5, 0, 0, ALU_SLT);
    vecs[3] = mk(OP_LW,    0, 5, 0, 1, 6, 7, 8, 0, ALU_ADD);
    vecs[4] = mk(OP_SW,    0, 4, 0, 1, 6, 9, 0, 0, ALU_ADD);
    vecs[5] = mk(OP_BEQ,   1, 3, 0, 1, 10, 0, 0, 1, ALU_SUB);
    vecs[6] = mk(OP_BNE,   1, 3, 0, 1, 10, 0, 0, 0, ALU_SUB);
    vecs[7] = mk(OP_BEQ,   0, 3, 0, 1, 10, 0, 0, 0, ALU_SUB);
    vecs[8] = mk(OP_BNE,   0, 3, 0, 1, 10, 0, 0, 1, ALU_SUB);
    vecs[9] = mk(OP_J,     0, 3, 0, 1, 11, 0, 0, 1, ALU_ADD);

    ops = '{OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, 6'h3f};

    for (int i = 0; i < 3; i++) begin
      cyc_step(1'b1, OP_RTYPE, 1'b0, 1'b1);
      check($sformatf("reset outputs c%0d", i), int'(all_out), 0);
    end
    cyc_step(1'b0, OP_RTYPE, 1'b0, 1'b0);
    check("release state", state_o, 0);
    check("release mem_read", mem_read_o, 1);
    check("release pc_write stalled", pc_write_o, 0);
    check("release ir_write stalled", ir_write_o, 0);

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        cyc_step(1'b0, vecs[v].op, vecs[v].z, 1'b1);
        check($sformatf("vec%0d state c%0d", v, i), state_o, vecs[v].st[i]);
        check($sformatf("vec%0d done c%0d", v, i), instr_done_o, (i == vecs[v].n - 1) ? 1 : 0);
        if (i == 2) check($sformatf("vec%0d alu_op", v), alu_op_o, vecs[v].alu2);
        if (i == vecs[v].n - 1) begin
          check($sformatf("vec%0d pc_write last", v), pc_write_o, vecs[v].pcw_last);
          if (vecs[v].op == OP_BEQ || vecs[v].op == OP_BNE)
            check($sformatf("vec%0d pc_source", v), pc_source_o, 1);
        end
      end
    end

    run_instr(OP_LW, 1'b0, 0, 2, a);
    check("lw wait cycles", a.cycles, 7);
    check("lw wait iord", a.iord, 3);
    compare("lw wait", a, model(OP_LW, 1'b0, 0, 2));

    run_instr(6'h3f, 1'b0, 0, 0, a);
    check("illegal count", a.ill, 1);
    check("illegal reg_write", a.regw, 0);
    check("illegal mem_write", a.memw, 0);
    cyc_step(1'b0, OP_RTYPE, 1'b0, 1'b0);
    check("after illegal state", state_o, 0);
    check("after illegal illegal_o", illegal_o, 0);

    cyc_step(1'b0, OP_SW, 1'b0, 1'b1);
    check("sw abort fetch", state_o, 0);
    cyc_step(1'b0, OP_SW, 1'b0, 1'b1);
    check("sw abort decode", state_o, 1);
    cyc_step(1'b1, OP_SW, 1'b0, 1'b1);
    check("sw abort rst mem_write", mem_write_o, 0);
    cyc_step(1'b1, OP_SW, 1'b0, 1'b1);
    check("sw abort held mem_write", mem_write_o, 0);
    cyc_step(1'b0, OP_SW, 1'b0, 1'b0);
    check("sw abort release state", state_o, 0);
    check("sw abort release mem_write", mem_write_o, 0);
    check("sw abort release mem_read", mem_read_o, 1);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      logic       z;
      int         fw, mw;
      op = ops[$urandom_range(0, 8)];
      z  = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      e  = model(op, z, fw, mw);
      run_instr(op, z, fw, mw, a);
      compare($sformatf("rand%0d op%0h", n, op), a, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Finite-state controller that sequences a multi-cycle MIPS-subset datapath: one shared ALU, one unified instruction/data memory port, and the instruction, A/B and ALUOut registers. It issues each instruction as 3–5 steps: fetch, decode, execute, memory, write-back. It replaces the single-cycle Decoder in the multi-cycle CPU top and drives every mux select and register enable there. Memory accesses use a ready handshake, so slow memory stretches only the FETCH/MEM states.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- instr_op_i  in  6  opcode from the instruction register, bits [31:26]
- zero_i  in  1  ALU zero flag, valid in the BRANCH state
- mem_ready_i  in  1  memory completed the current access this cycle
- pc_write_o  out  1  PC load enable
- iord_o  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  instruction register load enable
- reg_dst_o  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg_o  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  1  ALU source A: 0 = PC, 1 = A register
- alu_src_b_o  out  2  ALU source B: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op_o  out  3  ALU operation class, sent to ALU_Ctrl
- pc_source_o  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done_o  out  1  one-cycle pulse in the last step of each instruction
- illegal_o  out  1  one-cycle pulse when the decoded opcode is unsupported
- state_o  out  4  current state encoding, for debug

## Operation
- Supported opcodes:
  - R-type 000000
  - addi 001000
  - slti 001010
  - lw 100011
  - sw 101011
  - beq 000100
  - bne 000101
  - j 000010
- States, with their encoding and what each does:
  - FETCH (0): mem_read_o, iord_o = 0, ir_write_o, alu_src_a_o = 0, alu_src_b_o = 01, alu_op_o = ADD, pc_source_o = 00. pc_write_o and ir_write_o are high only when mem_ready_i = 1. Stays in FETCH while mem_ready_i = 0; goes to DECODE when it is 1.
  - DECODE (1): alu_src_a_o = 0, alu_src_b_o = 11, alu_op_o = ADD (precomputes the branch target into ALUOut). Next state by opcode:
    - R-type → EXEC_R
    - addi → EXEC_I
    - slti → EXEC_I
    - lw → MEM_ADDR
    - sw → MEM_ADDR
    - beq → BRANCH
    - bne → BRANCH
    - j → JUMP
    - any other opcode → FETCH, with illegal_o = 1 and no writes
  - EXEC_R (2): src A = A, src B = B, alu_op_o = FUNCT → WB_R.
  - WB_R (3): reg_dst_o = 1, mem_to_reg_o = 0, reg_write_o, instr_done_o → FETCH.
  - EXEC_I (4): src A = A, src B = immediate, alu_op_o = ADD for addi, SLT for slti → WB_I.
  - WB_I (5): reg_dst_o = 0, mem_to_reg_o = 0, reg_write_o, instr_done_o → FETCH.
  - MEM_ADDR (6): src A = A, src B = immediate, alu_op_o = ADD → MEM_RD for lw, MEM_WR for sw.
  - MEM_RD (7): mem_read_o, iord_o = 1. Stays while mem_ready_i = 0; → WB_MEM when it is 1.
  - WB_MEM (8): reg_dst_o = 0, mem_to_reg_o = 1, reg_write_o, instr_done_o → FETCH.
  - MEM_WR (9): mem_write_o, iord_o = 1. Stays while mem_ready_i = 0. When it is 1: instr_done_o, → FETCH.
  - BRANCH (10): src A = A, src B = B, alu_op_o = SUB, pc_source_o = 01. pc_write_o = zero_i for beq, !zero_i for bne. instr_done_o → FETCH.
  - JUMP (11): pc_source_o = 10, pc_write_o = 1, instr_done_o → FETCH.
- Every output not listed for a state is 0 in that state.
- The opcode is sampled in DECODE and held in an internal register for the rest of the instruction, because instr_op_i stays valid only while the instruction register is not written.
- Encodings 12–15 are unreachable. If ever reached, the next state is FETCH and all outputs are 0.

## Timing
- Reset: while rst_i = 1, every output is 0 and state_o = 0. On the first rising edge after rst_i falls the controller is in FETCH with outputs active.
- rst_i asserted mid-instruction aborts it at the next edge: no write strobe follows and the next state is FETCH.
- All outputs are decoded from the state register (Moore), with three exceptions:
  - pc_write_o and ir_write_o in FETCH follow mem_ready_i combinationally.
  - pc_write_o in BRANCH follows zero_i combinationally.
  - instr_done_o in MEM_WR follows mem_ready_i combinationally.
- Cycle counts with mem_ready_i held at 1:
  - R-type: 4
  - addi / slti: 4
  - lw: 5
  - sw: 4
  - beq / bne: 3
  - j: 3
  - Each cycle that mem_ready_i is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- A request (mem_read_o or mem_write_o) stays asserted with a constant iord_o until the cycle in which mem_ready_i = 1.

## Structure
- Shared package mc_pkg holds:
  - the state enum and its 4-bit encodings
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J
  - alu_op_o encodings: ADD = 000, SUB = 001, FUNCT = 010, SLT = 011
  - source-select constants for alu_src_b_o and pc_source_o
- Sub-module multicycle_ctrl_outdec: combinational decode of state, held opcode, zero_i and mem_ready_i into all control outputs. The parent contains only the state register, the opcode register and next-state logic.

## Test plan
- Reset held 3 cycles, then released, mem_ready_i = 1 → all outputs 0 during reset; state_o = 0 with mem_read_o = 1 in the first cycle after release.
- R-type (op 000000), mem_ready_i = 1 → state_o goes 0, 1, 2, 3; reg_write_o = 1 and reg_dst_o = 1 only in cycle 4; instr_done_o pulses once.
- lw (op 100011) with mem_ready_i low for 2 cycles in MEM_RD → 7 cycles total; mem_read_o = 1 and iord_o = 1 held for 3 cycles; mem_to_reg_o = 1 with reg_write_o = 1 in WB_MEM.
- beq with zero_i = 1, then bne with zero_i = 1 → pc_write_o = 1 with pc_source_o = 01 in BRANCH for beq; pc_write_o = 0 for bne; each instruction takes 3 cycles.
- Opcode 111111 → illegal_o pulses in DECODE; FETCH follows; reg_write_o and mem_write_o never assert.
- sw (op 101011) with rst_i asserted during MEM_ADDR → mem_write_o never asserts; state_o = 0 after reset is released.
